// File: rtl/program_memory_if.sv
// rtl/program_memory_if.sv - fetch bus and program-load stream between source, core and program memory
// master drives address/fetch and load stream; slave is the memory responder.
interface program_memory_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] addr_in;
  logic              fetch_en;
  logic [DATA_W-1:0] data_out;
  logic              cpu_hold;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   loaded_count;

  modport master (
    output addr_in, fetch_en, load_start, load_valid, load_data, load_last,
    input  data_out, cpu_hold, load_ready, load_done, loaded_count
  );

  modport slave (
    input  addr_in, fetch_en, load_start, load_valid, load_data, load_last,
    output data_out, cpu_hold, load_ready, load_done, loaded_count
  );
endinterface

// File: rtl/program_memory.sv
// rtl/program_memory.sv - instruction memory with streaming loader for the accumulator CPU
// Unwritten locations read as NOP_WORD; per-word written flags mask stale contents after a reload.
module program_memory #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 12,
  parameter logic [DATA_W-1:0]  NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  program_memory_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DEPTH-1:0]  r_flags;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data;
  logic              r_hold;
  logic              r_ready;
  logic              r_done;

  logic w_accept;
  logic w_final;

  // load_start has priority, so a word arriving with it is dropped.
  assign w_accept = (r_state == S_LOAD) && bus.load_valid && !bus.load_start;
  // A full-depth load ends on its own so the pointer never wraps onto address 0.
  assign w_final  = bus.load_last || (r_ptr == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_mem[r_ptr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_flags <= '0;
      r_data  <= NOP_WORD;
      r_hold  <= 1'b1;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.load_start) begin
        r_state <= S_LOAD;
        r_ptr   <= '0;
        r_count <= '0;
        r_flags <= '0;
        r_data  <= NOP_WORD;
        r_hold  <= 1'b1;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_data  <= NOP_WORD;
            r_hold  <= 1'b1;
            r_ready <= 1'b0;
          end
          S_LOAD: begin
            r_data <= NOP_WORD;
            if (w_accept) begin
              r_flags[r_ptr] <= 1'b1;
              r_ptr          <= r_ptr + 1'b1;
              r_count        <= r_count + 1'b1;
              if (w_final) begin
                r_state <= S_RUN;
                r_hold  <= 1'b0;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (bus.fetch_en) begin
              r_data <= r_flags[bus.addr_in] ? r_mem[bus.addr_in] : NOP_WORD;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.data_out     = r_data;
  assign bus.cpu_hold     = r_hold;
  assign bus.load_ready   = r_ready;
  assign bus.load_done    = r_done;
  assign bus.loaded_count = r_count;
endmodule

// File: tb/tb_program_memory.sv
// tb/tb_program_memory.sv - randomized self-checking bench for program_memory
// Reference model: plain array of words plus written marks, rebuilt on each load start.
module tb_program_memory;
  localparam int AW = 8;
  localparam int DW = 12;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  program_memory_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  program_memory #(.ADDR_W(AW), .DATA_W(DW), .NOP_WORD(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] m_mem [256];
  bit          m_wr  [256];
  int          m_ptr;
  int          m_count;

  function automatic logic [11:0] m_read(input int a);
    return m_wr[a] ? m_mem[a] : 12'h000;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
    m_ptr   = 0;
    m_count = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load_start();
    bus.load_start = 1'b1;
    bus.load_valid = 1'b0;
    tick();
    bus.load_start = 1'b0;
    m_clear();
  endtask

  task automatic push(input logic [11:0] d, input bit last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    m_mem[m_ptr] = d;
    m_wr[m_ptr]  = 1'b1;
    m_ptr        = (m_ptr + 1) % 256;
    m_count++;
  endtask

  task automatic fetch(input int a);
    bus.fetch_en = 1'b1;
    bus.addr_in  = a[7:0];
    tick();
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_clear();
    tick();
    n_total++; if (bus.data_out !== 12'h000) $display("FAIL reset_data got %h exp 000", bus.data_out); else n_pass++;
    n_total++; if (bus.cpu_hold !== 1'b1) $display("FAIL reset_hold got %b exp 1", bus.cpu_hold); else n_pass++;
    n_total++; if (bus.load_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", bus.load_ready); else n_pass++;
    n_total++; if (bus.loaded_count !== 9'd0) $display("FAIL reset_count got %0d exp 0", bus.loaded_count); else n_pass++;
    n_total++; if (bus.load_done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.load_done); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      bus.fetch_en = 1'b1;
      bus.addr_in  = 8'($urandom);
      tick();
      n_total++;
      if (bus.data_out !== 12'h000 || bus.cpu_hold !== 1'b1 || bus.load_ready !== 1'b0)
        $display("FAIL idle_hold cyc %0d got data=%h hold=%b ready=%b exp 000/1/0", i, bus.data_out, bus.cpu_hold, bus.load_ready);
      else n_pass++;
    end
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_basic_load();
    do_load_start();
    n_total++; if (bus.load_ready !== 1'b1 || bus.cpu_hold !== 1'b1) $display("FAIL basic_in_load got ready=%b hold=%b exp 1/1", bus.load_ready, bus.cpu_hold); else n_pass++;
    push(12'h105, 1'b0);
    n_total++; if (bus.load_done !== 1'b0) $display("FAIL basic_early_done got %b exp 0", bus.load_done); else n_pass++;
    push(12'h2A3, 1'b0);
    push(12'h3FF, 1'b1);
    n_total++; if (bus.load_done !== 1'b1) $display("FAIL basic_done got %b exp 1", bus.load_done); else n_pass++;
    n_total++; if (bus.loaded_count !== 9'(m_count)) $display("FAIL basic_count got %0d exp %0d", bus.loaded_count, m_count); else n_pass++;
    n_total++; if (bus.cpu_hold !== 1'b0 || bus.load_ready !== 1'b0) $display("FAIL basic_run got hold=%b ready=%b exp 0/0", bus.cpu_hold, bus.load_ready); else n_pass++;
    tick();
    n_total++; if (bus.load_done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", bus.load_done); else n_pass++;
    fetch(1);
    n_total++; if (bus.data_out !== 12'h2A3) $display("FAIL basic_fetch1 got %h exp 2a3", bus.data_out); else n_pass++;
    tick();
    n_total++; if (bus.data_out !== 12'h2A3) $display("FAIL basic_hold_data got %h exp 2a3", bus.data_out); else n_pass++;
    fetch(7);
    n_total++; if (bus.data_out !== 12'h000) $display("FAIL basic_fetch7 got %h exp 000", bus.data_out); else n_pass++;
    n_total++; if (bus.loaded_count !== 9'd3) $display("FAIL basic_count_hold got %0d exp 3", bus.loaded_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [11:0] w0, w1;
    w0 = 12'($urandom);
    w1 = w0 ^ 12'h5A5;
    do_load_start();
    push(w0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b1;
      bus.load_data  = 12'($urandom);
      tick();
    end
    bus.load_last = 1'b0;
    n_total++; if (bus.load_ready !== 1'b1) $display("FAIL bp_still_loading got ready=%b exp 1", bus.load_ready); else n_pass++;
    push(w1, 1'b1);
    n_total++; if (bus.loaded_count !== 9'd2) $display("FAIL bp_count got %0d exp 2", bus.loaded_count); else n_pass++;
    for (int a = 0; a < 3; a++) begin
      fetch(a);
      n_total++; if (bus.data_out !== m_read(a)) $display("FAIL bp_fetch addr %0d got %h exp %h", a, bus.data_out, m_read(a)); else n_pass++;
    end
  endtask

  task automatic test_full_wrap();
    do_load_start();
    for (int i = 0; i < 256; i++) begin
      push(12'(i + 12'h100), 1'b0);
      if (i == 254) begin
        n_total++; if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b1) $display("FAIL wrap_early got done=%b ready=%b exp 0/1", bus.load_done, bus.load_ready); else n_pass++;
      end
    end
    n_total++; if (bus.load_done !== 1'b1) $display("FAIL wrap_done got %b exp 1", bus.load_done); else n_pass++;
    n_total++; if (bus.loaded_count !== 9'd256) $display("FAIL wrap_count got %0d exp 256", bus.loaded_count); else n_pass++;
    n_total++; if (bus.cpu_hold !== 1'b0) $display("FAIL wrap_hold got %b exp 0", bus.cpu_hold); else n_pass++;
    fetch(0);
    n_total++; if (bus.data_out !== 12'h100) $display("FAIL wrap_fetch0 got %h exp 100", bus.data_out); else n_pass++;
    fetch(255);
    n_total++; if (bus.data_out !== 12'h1FF) $display("FAIL wrap_fetch255 got %h exp 1ff", bus.data_out); else n_pass++;
    fetch(128);
    n_total++; if (bus.data_out !== m_read(128)) $display("FAIL wrap_fetch128 got %h exp %h", bus.data_out, m_read(128)); else n_pass++;
  endtask

  task automatic test_reload_masking();
    do_load_start();
    for (int i = 0; i < 5; i++) push(12'($urandom) | 12'h800, i == 4);
    fetch(3);
    n_total++; if (bus.data_out !== m_read(3)) $display("FAIL reload_pre3 got %h exp %h", bus.data_out, m_read(3)); else n_pass++;
    bus.fetch_en = 1'b1;
    bus.addr_in  = 8'd3;
    do_load_start();
    bus.fetch_en = 1'b0;
    n_total++; if (bus.data_out !== 12'h000 || bus.cpu_hold !== 1'b1) $display("FAIL reload_start got data=%h hold=%b exp 000/1", bus.data_out, bus.cpu_hold); else n_pass++;
    push(12'hAAA, 1'b0);
    n_total++; if (bus.cpu_hold !== 1'b1) $display("FAIL reload_hold got %b exp 1", bus.cpu_hold); else n_pass++;
    push(12'hBBB, 1'b1);
    n_total++; if (bus.loaded_count !== 9'd2) $display("FAIL reload_count got %0d exp 2", bus.loaded_count); else n_pass++;
    fetch(3);
    n_total++; if (bus.data_out !== 12'h000) $display("FAIL reload_mask3 got %h exp 000", bus.data_out); else n_pass++;
    fetch(1);
    n_total++; if (bus.data_out !== 12'hBBB) $display("FAIL reload_fetch1 got %h exp bbb", bus.data_out); else n_pass++;
  endtask

  task automatic test_restart_in_load();
    logic [11:0] w;
    do_load_start();
    push(12'h321, 1'b0);
    push(12'h654, 1'b0);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 12'hDEA;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    m_clear();
    w = 12'($urandom);
    push(w, 1'b1);
    n_total++; if (bus.loaded_count !== 9'd1) $display("FAIL restart_count got %0d exp 1", bus.loaded_count); else n_pass++;
    fetch(0);
    n_total++; if (bus.data_out !== w) $display("FAIL restart_fetch0 got %h exp %h", bus.data_out, w); else n_pass++;
    fetch(1);
    n_total++; if (bus.data_out !== 12'h000) $display("FAIL restart_fetch1 got %h exp 000", bus.data_out); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    logic [11:0] w;
    do_load_start();
    for (int i = 0; i < 3; i++) push(12'hE00 | 12'(i), 1'b0);
    rst = 1'b1;
    bus.load_valid = 1'b1;
    tick();
    rst = 1'b0;
    bus.load_valid = 1'b0;
    m_clear();
    n_total++; if (bus.loaded_count !== 9'd0) $display("FAIL midrst_count got %0d exp 0", bus.loaded_count); else n_pass++;
    n_total++; if (bus.cpu_hold !== 1'b1 || bus.load_ready !== 1'b0 || bus.data_out !== 12'h000)
      $display("FAIL midrst_idle got hold=%b ready=%b data=%h exp 1/0/000", bus.cpu_hold, bus.load_ready, bus.data_out);
    else n_pass++;
    bus.load_valid = 1'b1;
    bus.load_last  = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    n_total++; if (bus.load_done !== 1'b0 || bus.loaded_count !== 9'd0) $display("FAIL midrst_idle_ignores got done=%b count=%0d exp 0/0", bus.load_done, bus.loaded_count); else n_pass++;
    do_load_start();
    for (int i = 0; i < 6; i++) begin
      w = 12'($urandom) & 12'h0FF;
      push(w, i == 5);
    end
    fetch(2);
    n_total++; if (bus.data_out !== m_read(2)) $display("FAIL midrst_fetch2 got %h exp %h", bus.data_out, m_read(2)); else n_pass++;
  endtask

  task automatic test_random_back_to_back();
    int          n;
    int          a;
    bit          fe;
    logic [11:0] exp_data;
    for (int it = 0; it < 4; it++) begin
      do_load_start();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        push(12'($urandom), i == n - 1);
      end
      n_total++; if (bus.load_done !== 1'b1 || bus.loaded_count !== 9'(m_count))
        $display("FAIL rand_load it %0d got done=%b count=%0d exp 1/%0d", it, bus.load_done, bus.loaded_count, m_count);
      else n_pass++;
      exp_data = bus.data_out;
      for (int k = 0; k < 30; k++) begin
        a  = $urandom_range(0, 31);
        fe = ($urandom_range(0, 3) != 0);
        bus.fetch_en = fe;
        bus.addr_in  = 8'(a);
        tick();
        if (fe) exp_data = m_read(a);
        n_total++; if (bus.data_out !== exp_data) $display("FAIL rand_fetch it %0d k %0d addr %0d got %h exp %h", it, k, a, bus.data_out, exp_data); else n_pass++;
      end
      bus.fetch_en = 1'b0;
    end
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    rst            = 1'b1;
    bus.addr_in    = '0;
    bus.fetch_en   = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    m_clear();
    test_reset();
    test_basic_load();
    test_backpressure();
    test_full_wrap();
    test_reload_masking();
    test_restart_in_load();
    test_reset_mid_load();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
